// File: rtl/id_stage_fwd.sv
// Decode stage with an integrated ID/EX pipeline register.
// Decodes the logic/shift/immediate subset, resolves operands through EX/MEM
// forwarding, stalls on load-use hazards and handshakes with IF/ID and EX.

package id_stage_fwd_pkg;
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  localparam logic [7:0] OP_NOP = 8'b0000_0000;
  localparam logic [7:0] OP_AND = 8'b0010_0100;
  localparam logic [7:0] OP_OR  = 8'b0010_0101;
  localparam logic [7:0] OP_XOR = 8'b0010_0110;
  localparam logic [7:0] OP_NOR = 8'b0010_0111;
  localparam logic [7:0] OP_SLL = 8'b0111_1100;
  localparam logic [7:0] OP_SRL = 8'b0000_0010;
  localparam logic [7:0] OP_SRA = 8'b0000_0011;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_ANDI    = 6'h0c;
  localparam logic [5:0] OPC_ORI     = 6'h0d;
  localparam logic [5:0] OPC_XORI    = 6'h0e;
  localparam logic [5:0] OPC_LUI     = 6'h0f;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  // Operand/destination format of a decoded instruction.
  typedef enum logic [2:0] {
    FMT_NONE,   // unsupported encoding
    FMT_RLOG,   // rs, rt -> rd
    FMT_SHAMT,  // sa, rt -> rd
    FMT_SHVAR,  // rs, rt -> rd
    FMT_IMM,    // rs, zext(imm) -> rt
    FMT_LUI     // rs, {imm,16'h0} -> rt
  } fmt_e;
endpackage

module id_stage_fwd
  import id_stage_fwd_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter bit FWD_EN     = 1'b1,
  parameter bit LDSTALL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [31:0]       inst_i,
  input  logic              inst_valid_i,
  output logic              id_ready_o,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [4:0]        reg1_addr_o,
  output logic [4:0]        reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [4:0]        ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wreg_i,
  input  logic [4:0]        mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              flush_i,
  input  logic              ex_ready_i,
  output logic              ex_valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [2:0]        alusel_o,
  output logic [7:0]        aluop_o,
  output logic [DATA_W-1:0] reg1_data_o,
  output logic [DATA_W-1:0] reg2_data_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic              inst_invalid_o
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;

  assign opcode = inst_i[31:26];
  assign rs     = inst_i[25:21];
  assign rt     = inst_i[20:16];
  assign rd     = inst_i[15:11];
  assign sa     = inst_i[10:6];
  assign funct  = inst_i[5:0];
  assign imm16  = inst_i[15:0];

  fmt_e              fmt;
  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic              dec_rd1, dec_rd2, dec_wreg, dec_inval;
  logic [DATA_W-1:0] dec_imm;
  logic [4:0]        dec_wd;
  logic [DATA_W-1:0] op1, op2;
  logic              src_hit, hazard, advance;

  // Classify the instruction word into an ALU operation and operand format.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    fmt        = FMT_NONE;
    dec_aluop  = OP_NOP;
    dec_alusel = SEL_NOP;
    case (opcode)
      OPC_ORI:  begin fmt = FMT_IMM; dec_aluop = OP_OR;  dec_alusel = SEL_LOGIC; end
      OPC_ANDI: begin fmt = FMT_IMM; dec_aluop = OP_AND; dec_alusel = SEL_LOGIC; end
      OPC_XORI: begin fmt = FMT_IMM; dec_aluop = OP_XOR; dec_alusel = SEL_LOGIC; end
      OPC_LUI:  begin fmt = FMT_LUI; dec_aluop = OP_OR;  dec_alusel = SEL_LOGIC; end
      OPC_SPECIAL: begin
        case (funct)
          FN_AND:  begin fmt = FMT_RLOG;  dec_aluop = OP_AND; dec_alusel = SEL_LOGIC; end
          FN_OR:   begin fmt = FMT_RLOG;  dec_aluop = OP_OR;  dec_alusel = SEL_LOGIC; end
          FN_XOR:  begin fmt = FMT_RLOG;  dec_aluop = OP_XOR; dec_alusel = SEL_LOGIC; end
          FN_NOR:  begin fmt = FMT_RLOG;  dec_aluop = OP_NOR; dec_alusel = SEL_LOGIC; end
          FN_SLL:  begin fmt = FMT_SHAMT; dec_aluop = OP_SLL; dec_alusel = SEL_SHIFT; end
          FN_SRL:  begin fmt = FMT_SHAMT; dec_aluop = OP_SRL; dec_alusel = SEL_SHIFT; end
          FN_SRA:  begin fmt = FMT_SHAMT; dec_aluop = OP_SRA; dec_alusel = SEL_SHIFT; end
          FN_SLLV: begin fmt = FMT_SHVAR; dec_aluop = OP_SLL; dec_alusel = SEL_SHIFT; end
          FN_SRLV: begin fmt = FMT_SHVAR; dec_aluop = OP_SRL; dec_alusel = SEL_SHIFT; end
          FN_SRAV: begin fmt = FMT_SHVAR; dec_aluop = OP_SRA; dec_alusel = SEL_SHIFT; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Expand the format into read enables, immediate and destination.
  always_comb begin
    dec_rd1  = 1'b0;
    dec_rd2  = 1'b0;
    dec_imm  = '0;
    dec_wd   = rd;
    dec_wreg = 1'b1;
    case (fmt)
      FMT_RLOG, FMT_SHVAR: begin dec_rd1 = 1'b1; dec_rd2 = 1'b1; end
      FMT_SHAMT: begin dec_rd2 = 1'b1; dec_imm = DATA_W'(sa); end
      FMT_IMM:   begin dec_rd1 = 1'b1; dec_imm = DATA_W'(imm16); dec_wd = rt; end
      FMT_LUI:   begin dec_rd1 = 1'b1; dec_imm = DATA_W'({imm16, 16'h0000}); dec_wd = rt; end
      default:   begin dec_wd = 5'd0; dec_wreg = 1'b0; end
    endcase
  end

  assign dec_inval   = (fmt == FMT_NONE);
  assign reg1_read_o = dec_rd1;
  assign reg2_read_o = dec_rd2;
  assign reg1_addr_o = rs;
  assign reg2_addr_o = rt;

  // Operand select: immediate when the port is unused, $0 is hard zero, EX beats MEM beats regfile.
  always_comb begin
    op1 = dec_imm;
    if (dec_rd1) begin
      if (rs == 5'd0)                               op1 = '0;
      else if (FWD_EN && ex_wreg_i && ex_wd_i == rs)   op1 = ex_wdata_i;
      else if (FWD_EN && mem_wreg_i && mem_wd_i == rs) op1 = mem_wdata_i;
      else                                          op1 = reg1_data_i;
    end
    op2 = dec_imm;
    if (dec_rd2) begin
      if (rt == 5'd0)                               op2 = '0;
      else if (FWD_EN && ex_wreg_i && ex_wd_i == rt)   op2 = ex_wdata_i;
      else if (FWD_EN && mem_wreg_i && mem_wd_i == rt) op2 = mem_wdata_i;
      else                                          op2 = reg2_data_i;
    end
  end

  // A load in EX cannot supply data yet, so a consumer of its destination must wait.
  assign src_hit = (dec_rd1 && ex_wd_i == rs) || (dec_rd2 && ex_wd_i == rt);
  assign hazard  = LDSTALL_EN && inst_valid_i && ex_valid_o && ex_wreg_i && ex_is_load_i
                   && (ex_wd_i != 5'd0) && src_hit;
  assign advance    = !ex_valid_o || ex_ready_i;
  assign id_ready_o = flush_i || (advance && !hazard);

  // ID/EX register: load on accept, bubble on flush/stall/empty, hold while EX is busy.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments and clears asynchronously on reset.
    if (!rst) begin
      ex_valid_o     <= 1'b0;
      pc_o           <= '0;
      alusel_o       <= SEL_NOP;
      aluop_o        <= OP_NOP;
      reg1_data_o    <= '0;
      reg2_data_o    <= '0;
      wd_o           <= 5'd0;
      wreg_o         <= 1'b0;
      inst_invalid_o <= 1'b0;
    end else if (flush_i || advance) begin
      if (!flush_i && inst_valid_i && !hazard) begin
        ex_valid_o     <= 1'b1;
        pc_o           <= pc_i;
        alusel_o       <= dec_alusel;
        aluop_o        <= dec_aluop;
        reg1_data_o    <= op1;
        reg2_data_o    <= op2;
        wd_o           <= dec_wd;
        wreg_o         <= dec_wreg;
        inst_invalid_o <= dec_inval;
      end else begin
        ex_valid_o     <= 1'b0;
        wreg_o         <= 1'b0;
        inst_invalid_o <= 1'b0;
      end
    end
  end

endmodule
